// File: rtl/pc_word_deserializer.sv
// Routes 32b PC words {code, payload} to the CONF/TIME/BD channels, reassembling multi-word
// messages LSB-word first. Unknown codes and broken messages are dropped and counted.
module pc_word_deserializer #(
    parameter int unsigned NPCcode   = 8,
    parameter int unsigned NPCdata   = 24,
    parameter int unsigned NCONF     = 24,
    parameter int unsigned Ntime     = 48,
    parameter int unsigned NBDdata   = 40,
    parameter int unsigned CONF_code = 0,
    parameter int unsigned TIME_code = 1,
    parameter int unsigned BD_code   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_in_v,
    input  logic [NPCcode-1:0] PC_in_code,
    input  logic [NPCdata-1:0] PC_in_data,
    output logic               PC_in_a,
    output logic               conf_v,
    output logic [NCONF-1:0]   conf_d,
    input  logic               conf_a,
    output logic               time_v,
    output logic [Ntime-1:0]   time_d,
    input  logic               time_a,
    output logic               bd_v,
    output logic [NBDdata-1:0] bd_d,
    input  logic               bd_a,
    output logic [7:0]         err_count,
    output logic               err_pulse
);

    localparam int unsigned WConf = (NCONF + NPCdata - 1) / NPCdata;
    localparam int unsigned WTime = (Ntime + NPCdata - 1) / NPCdata;
    localparam int unsigned WBd   = (NBDdata + NPCdata - 1) / NPCdata;
    localparam int unsigned WMax  = (WConf > WTime) ? ((WConf > WBd) ? WConf : WBd)
                                                    : ((WTime > WBd) ? WTime : WBd);
    localparam int unsigned AccW  = WMax * NPCdata;
    localparam int unsigned IdxW  = (WMax > 1) ? $clog2(WMax) : 1;

    typedef enum logic {StIdle, StAssemble} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NPCcode-1:0] code_q, code_d;
    logic [AccW-1:0]    acc_q, acc_d;

    logic               conf_v_q, conf_v_d;
    logic [NCONF-1:0]   conf_d_q, conf_d_d;
    logic               time_v_q, time_v_d;
    logic [Ntime-1:0]   time_d_q, time_d_d;
    logic               bd_v_q, bd_v_d;
    logic [NBDdata-1:0] bd_d_q, bd_d_d;
    logic [7:0]         err_count_q, err_count_d;
    logic               err_pulse_q, err_pulse_d;

    logic               is_conf, is_time, is_bd, known;
    logic               cont, drop_partial, is_final, stall, xfer;
    logic [IdxW-1:0]    eff_idx, last_idx;
    logic [AccW-1:0]    assembled;
    logic [1:0]         err_inc;
    logic [8:0]         err_sum;

    // Input decode and acceptance; a word from a different code restarts at index 0.
    always_comb begin
        is_conf      = (PC_in_code == NPCcode'(CONF_code));
        is_time      = (PC_in_code == NPCcode'(TIME_code));
        is_bd        = (PC_in_code == NPCcode'(BD_code));
        known        = is_conf || is_time || is_bd;
        cont         = (state_q == StAssemble) && (PC_in_code == code_q);
        drop_partial = (state_q == StAssemble) && !cont;
        eff_idx      = cont ? idx_q : '0;

        last_idx = '0;
        stall    = 1'b0;
        if (is_conf) begin
            last_idx = IdxW'(WConf - 1);
            stall    = conf_v_q && !conf_a;
        end else if (is_time) begin
            last_idx = IdxW'(WTime - 1);
            stall    = time_v_q && !time_a;
        end else if (is_bd) begin
            last_idx = IdxW'(WBd - 1);
            stall    = bd_v_q && !bd_a;
        end

        is_final = known && (eff_idx == last_idx);
        PC_in_a  = !reset && !(is_final && stall);
        xfer     = PC_in_v && PC_in_a;

        assembled = cont ? acc_q : '0;
        for (int i = 0; i < int'(WMax); i++) begin
            if (eff_idx == IdxW'(i)) begin
                assembled[i*NPCdata +: NPCdata] = PC_in_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        code_d    = code_q;
        acc_d     = acc_q;
        conf_v_d  = conf_v_q && !conf_a;
        conf_d_d  = conf_d_q;
        time_v_d  = time_v_q && !time_a;
        time_d_d  = time_d_q;
        bd_v_d    = bd_v_q && !bd_a;
        bd_d_d    = bd_d_q;
        err_inc   = 2'd0;

        if (xfer) begin
            err_inc = {1'b0, drop_partial} + {1'b0, !known};
            state_d = StIdle;
            idx_d   = '0;
            if (is_final) begin
                if (is_conf) begin
                    conf_v_d = 1'b1;
                    conf_d_d = assembled[NCONF-1:0];
                end else if (is_time) begin
                    time_v_d = 1'b1;
                    time_d_d = assembled[Ntime-1:0];
                end else begin
                    bd_v_d = 1'b1;
                    bd_d_d = assembled[NBDdata-1:0];
                end
            end else if (known) begin
                state_d = StAssemble;
                idx_d   = eff_idx + IdxW'(1);
                code_d  = PC_in_code;
                acc_d   = assembled;
            end
        end

        err_sum     = {1'b0, err_count_q} + {7'd0, err_inc};
        err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        err_pulse_d = (err_inc != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            code_q      <= '0;
            acc_q       <= '0;
            conf_v_q    <= 1'b0;
            conf_d_q    <= '0;
            time_v_q    <= 1'b0;
            time_d_q    <= '0;
            bd_v_q      <= 1'b0;
            bd_d_q      <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            acc_q       <= acc_d;
            conf_v_q    <= conf_v_d;
            conf_d_q    <= conf_d_d;
            time_v_q    <= time_v_d;
            time_d_q    <= time_d_d;
            bd_v_q      <= bd_v_d;
            bd_d_q      <= bd_d_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign conf_v    = conf_v_q;
    assign conf_d    = conf_d_q;
    assign time_v    = time_v_q;
    assign time_d    = time_d_q;
    assign bd_v      = bd_v_q;
    assign bd_d      = bd_d_q;
    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_pc_word_deserializer.sv
// Bench for pc_word_deserializer: message-level model with per-destination queues, checked on
// every falling edge, plus literal expectations for the directed messages and error counts.
module tb_pc_word_deserializer;

    localparam int NCONF   = 24;
    localparam int NTIME   = 48;
    localparam int NBD     = 40;
    localparam int NDATA   = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PC_in_v = 1'b0;
    logic [7:0]  PC_in_code = 8'd0;
    logic [23:0] PC_in_data = 24'd0;
    logic        PC_in_a;
    logic        conf_v, time_v, bd_v;
    logic [23:0] conf_d;
    logic [47:0] time_d;
    logic [39:0] bd_d;
    logic        conf_a = 1'b1, time_a = 1'b1, bd_a = 1'b1;
    logic [7:0]  err_count;
    logic        err_pulse;

    pc_word_deserializer dut (
        .clk        (clk),
        .reset      (reset),
        .PC_in_v    (PC_in_v),
        .PC_in_code (PC_in_code),
        .PC_in_data (PC_in_data),
        .PC_in_a    (PC_in_a),
        .conf_v     (conf_v),
        .conf_d     (conf_d),
        .conf_a     (conf_a),
        .time_v     (time_v),
        .time_d     (time_d),
        .time_a     (time_a),
        .bd_v       (bd_v),
        .bd_d       (bd_d),
        .bd_a       (bd_a),
        .err_count  (err_count),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Written only by the stimulus process; read by the checker.
    bit rand_sink = 1'b0;
    int probe_seq = 0;
    int probe_val = 0;

    // Model state, owned by the checker.
    logic [63:0] q_conf[$], q_time[$], q_bd[$];
    logic [23:0] parts[4];
    int          n_parts = 0;
    logic [7:0]  cur_code = 8'd0;
    int          model_err = 0;
    bit          model_pulse = 1'b0;
    int          seen_seq = 0;
    int          stall_cnt = 0;
    int          n_conf_pop = 0, n_time_pop = 0, n_bd_pop = 0;

    logic [63:0] conf_lit[2] = '{64'hABCDEF, 64'h000011};
    logic [63:0] time_lit[2] = '{64'h000001000002, 64'h000001000002};
    logic [63:0] bd_lit[2]   = '{64'h0078123456, 64'h0002000001};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic int words(input logic [7:0] c);
        case (c)
            8'd0:    return (NCONF + NDATA - 1) / NDATA;
            8'd1:    return (NTIME + NDATA - 1) / NDATA;
            8'd2:    return (NBD + NDATA - 1) / NDATA;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] mask(input int nbits);
        logic [63:0] m = '1;
        return m >> (64 - nbits);
    endfunction

    always @(negedge clk) begin
        int          w, n_eff, inc;
        bit          fin, stalled, exp_a;
        logic [63:0] msg, dummy;

        // Compare DUT against the model state reached after the last rising edge.
        w       = words(PC_in_code);
        n_eff   = (n_parts > 0 && PC_in_code == cur_code) ? n_parts : 0;
        fin     = (w > 0) && (n_eff + 1 == w);
        stalled = (PC_in_code == 8'd0 && q_conf.size() > 0 && !conf_a) ||
                  (PC_in_code == 8'd1 && q_time.size() > 0 && !time_a) ||
                  (PC_in_code == 8'd2 && q_bd.size() > 0 && !bd_a);
        exp_a   = reset ? 1'b0 : !(fin && stalled);
        chk("in_ack", PC_in_a, exp_a);
        chk("conf_v", conf_v, q_conf.size() != 0);
        if (q_conf.size() != 0) chk("conf_d", conf_d, q_conf[0]);
        chk("time_v", time_v, q_time.size() != 0);
        if (q_time.size() != 0) chk("time_d", time_d, q_time[0]);
        chk("bd_v", bd_v, q_bd.size() != 0);
        if (q_bd.size() != 0) chk("bd_d", bd_d, q_bd[0]);
        chk("err_count", err_count, model_err);
        chk("err_pulse", err_pulse, model_pulse);
        if (probe_seq != seen_seq) begin
            seen_seq = probe_seq;
            chk("err_literal", err_count, probe_val);
        end
        stall_cnt = (PC_in_v && !PC_in_a && !reset) ? stall_cnt + 1 : 0;
        chk("in_stall_bound", stall_cnt < 200, 1'b1);

        // Advance the model to the state after the coming rising edge.
        if (reset) begin
            q_conf.delete();
            q_time.delete();
            q_bd.delete();
            n_parts     = 0;
            model_err   = 0;
            model_pulse = 1'b0;
        end else begin
            model_pulse = 1'b0;
            if (q_conf.size() > 0 && conf_a) begin
                if (n_conf_pop < 2) chk("conf_literal", conf_d, conf_lit[n_conf_pop]);
                n_conf_pop++;
                dummy = q_conf.pop_front();
            end
            if (q_time.size() > 0 && time_a) begin
                if (n_time_pop < 2) chk("time_literal", time_d, time_lit[n_time_pop]);
                n_time_pop++;
                dummy = q_time.pop_front();
            end
            if (q_bd.size() > 0 && bd_a) begin
                if (n_bd_pop < 2) chk("bd_literal", bd_d, bd_lit[n_bd_pop]);
                n_bd_pop++;
                dummy = q_bd.pop_front();
            end
            if (PC_in_v && PC_in_a) begin
                inc = 0;
                if (n_parts > 0 && PC_in_code != cur_code) begin
                    inc++;
                    n_parts = 0;
                end
                if (w == 0) begin
                    inc++;
                end else begin
                    parts[n_parts] = PC_in_data;
                    n_parts++;
                    cur_code = PC_in_code;
                    if (n_parts == w) begin
                        msg = 64'd0;
                        for (int k = 0; k < n_parts; k++) msg |= 64'(parts[k]) << (NDATA * k);
                        case (PC_in_code)
                            8'd0:    q_conf.push_back(msg & mask(NCONF));
                            8'd1:    q_time.push_back(msg & mask(NTIME));
                            default: q_bd.push_back(msg & mask(NBD));
                        endcase
                        n_parts = 0;
                    end
                end
                model_err   = (model_err + inc > 255) ? 255 : model_err + inc;
                model_pulse = (inc != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_sink) begin
            conf_a = 1'($urandom_range(0, 1));
            time_a = 1'($urandom_range(0, 1));
            bd_a   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Holds the word until accepted; the checker flags an over-long stall.
    task automatic send(input logic [7:0] c, input logic [23:0] d);
        int t = 0;
        PC_in_v    = 1'b1;
        PC_in_code = c;
        PC_in_data = d;
        @(negedge clk);
        while (!PC_in_a && t < 250) begin
            tick();
            @(negedge clk);
            t++;
        end
        tick();
        PC_in_v = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic probe_err(input int v);
        probe_val = v;
        probe_seq++;
    endtask

    initial begin
        idle(2);
        reset = 1'b0;

        send(8'h00, 24'hABCDEF);
        idle(2);

        send(8'h01, 24'h000002);
        send(8'h01, 24'h000001);
        idle(2);

        bd_a = 1'b0;
        send(8'h02, 24'h123456);
        send(8'h02, 24'hFF0078);
        idle(5);
        send(8'h02, 24'h000001);
        fork
            send(8'h02, 24'h000002);
            begin
                idle(4);
                bd_a = 1'b1;
            end
        join
        idle(3);

        send(8'h07, 24'h000000);
        probe_err(1);
        idle(2);
        for (int i = 0; i < 299; i++) send(8'h07, 24'(i));
        idle(1);
        probe_err(255);
        idle(2);

        do_reset();
        send(8'h01, 24'hAAAAAA);
        send(8'h00, 24'h000011);
        probe_err(1);
        idle(3);

        send(8'h01, 24'h555555);
        do_reset();
        probe_err(0);
        send(8'h01, 24'h000002);
        send(8'h01, 24'h000001);
        idle(3);

        send(8'h02, 24'h111111);
        send(8'h09, 24'h222222);
        probe_err(2);
        idle(3);

        rand_sink = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 9);
            c = (r < 3) ? 8'h00 : (r < 6) ? 8'h01 : (r < 9) ? 8'h02 : 8'h07;
            send(c, 24'($urandom));
            idle($urandom_range(0, 2));
        end
        rand_sink = 1'b0;
        conf_a = 1'b1;
        time_a = 1'b1;
        bd_a   = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
